// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART data register and the transmit serializer.
// Launches one byte per start/busy handshake and reports level, overflow and launch timeouts.
module uart_tx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned START_TO = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow,
  output logic              o_start_err
);

  localparam int unsigned      CNT_W     = $clog2(START_TO + 1);
  localparam logic [ADDR_W:0]  LEVEL_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(START_TO - 1);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_tx_start, r_start_err;
  logic [7:0]        r_tx_data;

  logic w_full, w_empty, w_push, w_drop, w_pop, w_start_err_next;

  assign w_full  = (r_level == LEVEL_MAX);
  assign w_empty = (r_level == '0);
  // Full is judged on the start-of-cycle level, so a same-cycle pop never rescues a push.
  assign w_push  = i_wr_en & ~w_full & ~i_flush;
  assign w_drop  = i_wr_en & w_full & ~i_flush;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_pop            = 1'b0;
    w_start_err_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty && !i_tx_busy && !i_flush) begin
          w_pop        = 1'b1;
          w_state_next = StWaitBusy;
          w_cnt_next   = '0;
        end
      end
      StWaitBusy: begin
        if (i_tx_busy) begin
          w_state_next = StWaitDone;
        end else if (r_cnt == CNT_LAST) begin
          // Serializer never acknowledged; the byte is abandoned.
          w_start_err_next = 1'b1;
          w_state_next     = StIdle;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StWaitDone: begin
        if (!i_tx_busy) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_tx_start  <= w_pop;
      r_start_err <= w_start_err_next;
      if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_tx_start  = r_tx_start;
  assign o_tx_data   = r_tx_data;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;
  assign o_start_err = r_start_err;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO with launch controller between the memory-mapped UART data register and the UART transmit serializer.
- Buffers CPU byte writes so software does not have to poll busy status before every byte.
- Drains one byte at a time into the serializer's start/data/busy handshake.
- Reports level, full/empty, overflow and handshake-timeout status for the status register path.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); sets pointer width.
- START_TO, 8, cycles to wait for tx_busy to rise after tx_start before abandoning the launch.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  push request from bus decode, one byte per cycle
- wr_data  in  8  byte to push
- flush  in  1  synchronous FIFO clear
- clr_ovf  in  1  clears the overflow flag
- tx_busy  in  1  serializer busy
- tx_start  out  1  one-cycle launch pulse to serializer, registered
- tx_data  out  8  byte to serializer, registered, held stable until next launch
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  ADDR_W+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: a push was dropped
- start_err  out  1  one-cycle pulse: launch timed out

Behaviour:
- Reset (asynchronous, rst=1):
  - outputs: tx_start=0, tx_data=0, level=0, empty=1, full=0, overflow=0, start_err=0.
  - state: pointers=0, FSM=IDLE, timeout counter=0.
  - Reset mid-transfer discards all buffered bytes and any in-flight launch.
- Storage:
  - Circular buffer with ADDR_W-bit read/write pointers that wrap modulo DEPTH.
  - level is a separate counter; full and empty are decoded from level.
- Push:
  - wr_en=1 and full=0: store wr_data at the write pointer, advance the write pointer.
  - wr_en=1 and full=1: byte dropped, overflow set to 1. This holds even if a pop happens in the same cycle; full is evaluated at the start of the cycle.
- Pop: happens only in the FSM IDLE launch cycle (below).
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
- flush=1:
  - pointers and level go to 0, overflow goes to 0.
  - Any push in the same cycle is dropped and does not set overflow.
  - Flush does not affect the FSM; a byte already launched completes normally.
- overflow: cleared by clr_ovf or flush. A push that overflows in the same cycle as clr_ovf leaves overflow=1 (set wins).
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0, tx_busy=0 and flush=0, pop the head byte. Next edge: tx_data = head, tx_start = 1, go to WAIT_BUSY, timeout counter = 0. Otherwise stay in IDLE.
  - WAIT_BUSY: tx_start = 0 (pulse lasts exactly one cycle).
    - tx_busy=1: go to WAIT_DONE.
    - Else the counter increments; when it reaches START_TO-1 with tx_busy still 0, pulse start_err for one cycle and go to IDLE. The byte is lost, not re-queued.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Launch latency:
  - Write accepted in cycle N into an empty FIFO with FSM idle and tx_busy=0: empty=0 and level=1 visible in N+1; tx_start=1 with the byte on tx_data in N+2; level=0 in N+2.
  - Back-to-back bytes: the next tx_start comes no earlier than 1 cycle after tx_busy falls; the next pop happens in the IDLE cycle.
- tx_data changes only on a launch edge.

Test Plan:
- Reset then idle: rst pulse, no writes. Required: tx_start never asserts; empty=1; level=0; tx_data=0x00.
- Single byte, serializer model raises busy 1 cycle after start and holds it 10 cycles: write 0x55 in cycle N. Required: tx_start high only in N+2 with tx_data=0x55; no second start; level 1 then 0.
- Burst and ordering: write 0x01..0x05 on consecutive cycles while busy. Required: bytes reach the serializer in order 0x01..0x05, one start per busy-low window; level peaks at 4 or 5 and ends at 0.
- Overflow, DEPTH=16, tx_busy held at 1: write 17 bytes. Required: full=1 after the 16th; the 17th is dropped; overflow=1. Then clr_ovf: overflow=0 with level still 16. Then flush: level=0, empty=1.
- Timeout: tx_busy tied to 0, write 0xA5. Required: tx_start pulses with 0xA5; start_err pulses START_TO cycles later; FSM returns to IDLE; a following write 0x3C launches normally.
- Async reset mid-burst: 3 bytes queued, one in WAIT_DONE, assert rst between edges. Required: outputs go to reset values immediately; after release, level=0 and no tx_start until a new write.
